// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT0      = 1'b0;
    localparam logic PORT1      = 1'b1;
    localparam int   NUM_PORTS  = 2;
    localparam int   DEF_ADDR_W = 8;
    localparam int   DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant: round-robin on a tie when RR != 0, else port 0 wins.
module rr_arbiter2
    import dmem_arb_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       gnt
);

    always_comb begin
        valid = |req;
        gnt   = PORT0;
        if (req == 2'b11)
            gnt = (RR != 0) ? ~last_grant : PORT0;
        else if (req[1])
            gnt = PORT1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported DataMemory between the MEM stage (port 0) and the
// loader/debug port (port 1); one registered command per 3-cycle transaction.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    arb_state_t                         state, state_nx;
    cmd_t                               cmd, p0_cmd, p1_cmd;
    logic                               grant, last_grant;
    logic                               win_valid, win;
    logic [NUM_PORTS-1:0]               req;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_q;

    assign req    = {p1_req, p0_req};
    assign p0_cmd = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    assign p1_cmd = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

    rr_arbiter2 #(.RR(RR)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .valid      (win_valid),
        .gnt        (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Requests are only looked at in IDLE, so a req still high across the
    // RESP->IDLE edge is never double-counted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_valid) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd        <= '0;
            grant      <= PORT0;
            last_grant <= PORT1;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: if (win_valid) begin
                    cmd   <= (win == PORT1) ? p1_cmd : p0_cmd;
                    grant <= win;
                end
                ACCESS: if (!cmd.we) rdata_q[grant] <= mem_read_data;
                RESP:   last_grant <= grant;
                default: ;
            endcase
        end
    end

    // The bus address/data simply reflect the command register, so they hold
    // the last command outside ACCESS; only the write strobe is state-gated.
    assign mem_address    = cmd.addr;
    assign mem_write_data = cmd.wdata;
    assign mem_read_write = (state == ACCESS) && cmd.we;

    assign p0_ack   = (state == RESP) && (grant == PORT0);
    assign p1_ack   = (state == RESP) && (grant == PORT1);
    assign p0_rdata = rdata_q[PORT0];
    assign p1_rdata = rdata_q[PORT1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: per-port requester processes, a memory model, and an ack monitor.
module tb_dmem_arbiter;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } cmd_t;
    typedef struct { int port; logic [7:0] rdata; } exp_t;
    typedef struct { int port; logic [7:0] rdata; int cyc; int lat; } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   wr_pulses = 0;

    logic       p0_req, p0_we, p1_req, p1_we, p0_ack, p1_ack, mem_read_write;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata, p0_rdata, p1_rdata;
    logic [7:0] mem_address, mem_write_data, mem_read_data;

    logic       f_p0_req, f_p1_req, f_p0_ack, f_p1_ack, f_mem_read_write;
    logic [7:0] f_p0_rdata, f_p1_rdata, f_mem_address, f_mem_write_data, f_mem_read_data;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] shadow_rd [2];

    cmd_t q0[$], q1[$];
    int   iss0[$], iss1[$];
    exp_t exp_q[$];
    obs_t obs_q[$];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_write(mem_read_write), .mem_read_data(mem_read_data)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f_p0_req), .p0_we(1'b0), .p0_addr(8'h10), .p0_wdata(8'h00),
        .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
        .p1_req(f_p1_req), .p1_we(1'b0), .p1_addr(8'h11), .p1_wdata(8'h00),
        .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
        .mem_address(f_mem_address), .mem_write_data(f_mem_write_data),
        .mem_read_write(f_mem_read_write), .mem_read_data(f_mem_read_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    assign mem_read_data   = mem[mem_address];
    assign f_mem_read_data = f_mem_address ^ 8'hA5;
    always @(posedge clk) if (mem_read_write) mem[mem_address] <= mem_write_data;

    initial begin : mon
        obs_t o;
        forever begin
            @(negedge clk);
            if (mem_read_write) wr_pulses = wr_pulses + 1;
            if (p0_ack) begin
                o.port = 0; o.rdata = p0_rdata; o.cyc = cyc;
                o.lat = (iss0.size() > 0) ? cyc - iss0.pop_front() : -1;
                obs_q.push_back(o);
            end
            if (p1_ack) begin
                o.port = 1; o.rdata = p1_rdata; o.cyc = cyc;
                o.lat = (iss1.size() > 0) ? cyc - iss1.pop_front() : -1;
                obs_q.push_back(o);
            end
        end
    end

    // Requesters hold req until ack, drop (or present the next command) the cycle after.
    initial begin : drv0
        bit   done;
        cmd_t c;
        done = 0; p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        forever begin
            @(negedge clk);
            if (p0_req && done) begin done = 0; p0_req = 0; end
            if (!p0_req && q0.size() > 0) begin
                c = q0.pop_front();
                p0_we = c.we; p0_addr = c.addr; p0_wdata = c.wdata; p0_req = 1;
                iss0.push_back(cyc);
            end
            if (p0_ack) done = 1;
        end
    end

    initial begin : drv1
        bit   done;
        cmd_t c;
        done = 0; p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        forever begin
            @(negedge clk);
            if (p1_req && done) begin done = 0; p1_req = 0; end
            if (!p1_req && q1.size() > 0) begin
                c = q1.pop_front();
                p1_we = c.we; p1_addr = c.addr; p1_wdata = c.wdata; p1_req = 1;
                iss1.push_back(cyc);
            end
            if (p1_ack) done = 1;
        end
    end

    task automatic queue_txn(input int port, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata);
        cmd_t c;
        exp_t e;
        c.we = we; c.addr = addr; c.wdata = wdata;
        if (port == 0) q0.push_back(c); else q1.push_back(c);
        e.port = port;
        if (we) shadow[addr] = wdata;
        else    shadow_rd[port] = shadow[addr];
        e.rdata = shadow_rd[port];
        exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() >= n) begin ok = 1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        bit   ok, bad;
        exp_t e;
        obs_t o;
        queue_txn(0, 1'b1, 8'hF0, 8'h11);
        queue_txn(1, 1'b0, 8'hF0, 8'h00);
        bad = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || mem_read_write !== 1'b0) bad = 1;
        end
        checks++; if (bad) $display("FAIL reset_quiet: ack/strobe seen during reset"); else passes++;
        checks++; if ({mem_address, mem_write_data} !== 16'h0)
            $display("FAIL reset_bus: addr %h wdata %h, want 00 00", mem_address, mem_write_data); else passes++;
        checks++; if ({p0_rdata, p1_rdata} !== 16'h0)
            $display("FAIL reset_rdata: %h %h, want 00 00", p0_rdata, p1_rdata); else passes++;
        @(posedge clk); #2 rst_n = 1;
        wait_obs(2, ok);
        checks++; if (!ok) $display("FAIL reset_timeout: %0d acks, want 2", obs_q.size()); else passes++;
        if (ok) begin
            checks++; if (obs_q[0].port !== 0)
                $display("FAIL reset_first: port %0d acked first, want 0", obs_q[0].port); else passes++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.port !== e.port || o.rdata !== e.rdata)
                $display("FAIL reset_sb: port %0d rdata %h, want port %0d rdata %h", o.port, o.rdata, e.port, e.rdata);
            else passes++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_write_read;
        bit   ok;
        exp_t e;
        obs_t o;
        queue_txn(0, 1'b1, 8'h0A, 8'h5C);
        wait_obs(1, ok);
        checks++; if (!ok || obs_q[0].lat != 2)
            $display("FAIL wr_latency: got %0d, want 2", ok ? obs_q[0].lat : -1); else passes++;
        checks++; if (mem[8'h0A] !== 8'h5C) $display("FAIL wr_mem: mem[0A]=%h, want 5c", mem[8'h0A]); else passes++;
        queue_txn(1, 1'b0, 8'h0A, 8'h00);
        wait_obs(2, ok);
        queue_txn(1, 1'b1, 8'hFF, 8'hEE);
        wait_obs(3, ok);
        queue_txn(0, 1'b0, 8'hFF, 8'h00);
        wait_obs(4, ok);
        checks++; if (!ok) $display("FAIL wr_timeout: %0d acks, want 4", obs_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.port !== e.port || o.rdata !== e.rdata)
                $display("FAIL wr_sb: port %0d rdata %h, want port %0d rdata %h", o.port, o.rdata, e.port, e.rdata);
            else passes++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_preload_sweep;
        bit   ok;
        int   w0, w1;
        exp_t e;
        obs_t o;
        w0 = wr_pulses;
        for (int i = 0; i < 10; i++) queue_txn(1, 1'b1, 8'(i), 8'(i));
        wait_obs(10, ok);
        w1 = wr_pulses;
        checks++; if (w1 - w0 != 10) $display("FAIL sweep_writes: %0d strobes, want 10", w1 - w0); else passes++;
        for (int i = 0; i < 10; i++) queue_txn(0, 1'b0, 8'(i), 8'h00);
        wait_obs(20, ok);
        checks++; if (!ok) $display("FAIL sweep_timeout: %0d acks, want 20", obs_q.size()); else passes++;
        checks++; if (wr_pulses != w1) $display("FAIL sweep_spurious: %0d strobes in reads, want 0", wr_pulses - w1); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.port !== e.port || o.rdata !== e.rdata)
                $display("FAIL sweep_sb: port %0d rdata %h, want port %0d rdata %h", o.port, o.rdata, e.port, e.rdata);
            else passes++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_contention_rr;
        bit   ok;
        int   bad_gap, n0;
        exp_t e;
        obs_t o;
        obs_t oq[$];
        @(posedge clk); #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        shadow_rd[0] = 8'h00; shadow_rd[1] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            queue_txn(0, 1'b1, 8'(8'h20 + i), 8'(8'h30 + i));
            queue_txn(1, 1'b0, 8'(i), 8'h00);
        end
        wait_obs(10, ok);
        checks++; if (!ok) $display("FAIL rr_timeout: %0d acks, want 10", obs_q.size()); else passes++;
        oq = obs_q;
        bad_gap = 0; n0 = 0;
        foreach (oq[k]) begin
            if (oq[k].port == 0) n0++;
            if (k > 0 && oq[k].cyc - oq[k-1].cyc != 3) bad_gap++;
        end
        checks++; if (bad_gap != 0) $display("FAIL rr_spacing: %0d gaps not 3 cycles, want 0", bad_gap); else passes++;
        checks++; if (n0 != 5) $display("FAIL rr_share: p0 acks %0d, want 5", n0); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.port !== e.port || o.rdata !== e.rdata)
                $display("FAIL rr_sb: port %0d rdata %h, want port %0d rdata %h", o.port, o.rdata, e.port, e.rdata);
            else passes++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_fixed_priority;
        int n0, n1, nw, wait_c;
        bit seen;
        n0 = 0; n1 = 0; nw = 0;
        f_p0_req = 1; f_p1_req = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk); #1;
            if (f_p0_ack) n0++;
            if (f_p1_ack) n1++;
            if (f_mem_read_write) nw++;
        end
        checks++; if (n1 != 0 || n0 != 8) $display("FAIL fp_starve: p0 %0d p1 %0d acks, want 8 0", n0, n1); else passes++;
        checks++; if (f_p0_rdata !== (8'h10 ^ 8'hA5)) $display("FAIL fp_p0_rdata: %h, want b5", f_p0_rdata); else passes++;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin @(negedge clk); #1; seen = f_p0_ack; end
        @(negedge clk); f_p0_req = 0;
        seen = 0; wait_c = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk); #1; wait_c++;
            if (f_mem_read_write) nw++;
            seen = f_p1_ack;
        end
        checks++; if (!seen || wait_c > 3) $display("FAIL fp_p1_grant: ack after %0d cycles (seen %0d), want <=3", wait_c, seen); else passes++;
        checks++; if (f_p1_rdata !== (8'h11 ^ 8'hA5)) $display("FAIL fp_p1_rdata: %h, want b4", f_p1_rdata); else passes++;
        checks++; if (nw != 0) $display("FAIL fp_strobe: %0d write strobes, want 0", nw); else passes++;
        @(negedge clk); f_p1_req = 0;
    endtask

    task automatic test_reset_in_access;
        bit   ok, found, bad;
        cmd_t c;
        exp_t e;
        obs_t o;
        c.we = 1'b1; c.addr = 8'h03; c.wdata = 8'hFF;
        q0.push_back(c);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin @(posedge clk); #1; found = mem_read_write; end
        checks++; if (!found) $display("FAIL ria_access: write strobe never seen"); else passes++;
        #2 rst_n = 0;
        #1;
        checks++; if (mem_read_write !== 1'b0) $display("FAIL ria_strobe: %b after reset, want 0", mem_read_write); else passes++;
        bad = 0;
        repeat (2) begin @(negedge clk); #1; if (p0_ack || p1_ack) bad = 1; end
        checks++; if (bad || p0_rdata !== 8'h00) $display("FAIL ria_noack: ack %0d rdata %h, want 0 00", bad, p0_rdata); else passes++;
        checks++; if (mem[8'h03] !== 8'h03) $display("FAIL ria_mem: mem[03]=%h, want 03", mem[8'h03]); else passes++;
        @(posedge clk); #2 rst_n = 1;
        shadow_rd[0] = 8'h00; shadow_rd[1] = 8'h00;
        shadow[8'h03] = 8'hFF;
        e.port = 0; e.rdata = 8'h00;
        exp_q.push_back(e);
        wait_obs(1, ok);
        checks++; if (!ok) $display("FAIL ria_timeout: no ack after release"); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.port !== e.port || o.rdata !== e.rdata)
                $display("FAIL ria_sb: port %0d rdata %h, want port %0d rdata %h", o.port, o.rdata, e.port, e.rdata);
            else passes++;
        end
        checks++; if (mem[8'h03] !== 8'hFF) $display("FAIL ria_commit: mem[03]=%h, want ff", mem[8'h03]); else passes++;
    endtask

    initial begin
        f_p0_req = 0; f_p1_req = 0;
        shadow_rd[0] = 8'h00; shadow_rd[1] = 8'h00;
        test_reset;
        test_write_read;
        test_preload_sweep;
        test_contention_rr;
        test_fixed_priority;
        test_reset_in_access;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
